seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Multiplexed multi-digit 7-segment driver sitting directly downstream of the up/down/load counter stage. It accepts N packed 4-bit digit values and time-multiplexes them onto one shared active-low segment bus, driving one active-low digit enable per digit. Values are snapshotted once per refresh frame, so a counter update mid-scan never shows a torn display. It replaces the single-digit combinational display stage when more than one digit is fitted.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- REFRESH_HZ, 1000: full-frame refresh rate (all digits).
- N_DIGITS, 4: digit count, legal 2..8.
- BLANK_CYC, 16: anti-ghost blank cycles at the start of each digit dwell. Must be less than DWELL.
- Derived DWELL = CLK_HZ / (REFRESH_HZ * N_DIGITS) cycles per digit. Elaboration error if DWELL < 2.
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = scan/display; 0 = all digits dark, scan keeps running.
- digits_in  in  4*N_DIGITS  packed digit values; bits [3:0] = digit 0 (least significant).
- seg  out  [0:6]  segments a..g, seg[0]=a, active-low.
- an  out  N_DIGITS  digit enables, active-low; an[k] drives digit k.
- frame_start  out  1  one-cycle pulse when digit 0 dwell begins.

## Operation
- Prescaler presc counts 0..DWELL-1 and wraps. Digit index idx advances when presc == DWELL-1, wrapping from N_DIGITS-1 to 0.
- Snapshot register snap loads digits_in on the cycle that idx wraps to 0, and on the first cycle after reset release. Display always uses snap, never digits_in directly.
- Per dwell:
  - presc < BLANK_CYC: an all ones, seg all ones.
  - Otherwise: an[idx]=0, all other an bits 1; seg = decode(snap digit idx).
- Decode: 0-9 standard glyphs; 10-15 hex A, b, C, d, E, F.
- en=0: an all ones and seg all ones; presc, idx and snap continue to update normally.
- Reset: presc=0, idx=0, snap=0, seg=7'b1111111, an all ones, frame_start=0.
- Reset asserted mid-dwell: all outputs dark on the next edge; scan restarts at digit 0.

## Timing
- seg, an and frame_start are registered: one cycle from internal presc/idx state to the pins.
- Digit k lit window per frame: DWELL-BLANK_CYC cycles. Frame period: N_DIGITS*DWELL cycles.
- frame_start is high for the single cycle in which the pins first reflect idx=0, presc=0.
- digits_in changing at any cycle appears on the pins at the next frame boundary and never earlier; a whole frame always shows one consistent snapshot.
- Simultaneous digits_in change and snapshot load: the new value is captured.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking.
  - Digit k>0 is dark (seg all ones, an[k] still low for its window) when snap digits k..N_DIGITS-1 are all zero.
  - Digit 0 is always shown, so the value 0 displays as a single "0".
- DISP_LZB_EN undefined: every digit is shown, including leading zeros.

## Structure
- Shared package seg7_pkg:
  - typedef seg_t (logic [0:6]).
  - Constants SEG_BLANK = 7'b1111111 and the 16-entry glyph table.
- Sub-module seg7_decoder: combinational, 4-bit value to seg_t lookup from seg7_pkg. It is reusable by the existing single-digit path.
- Scan logic (presc, idx, snap, blanking, LZB) lives in seg7_scan_mux itself.

## Test plan
All runs use CLK_HZ=800, REFRESH_HZ=50, N_DIGITS=4, BLANK_CYC=1, giving DWELL=4.
- Reset held 3 cycles -> seg=1111111, an=1111, frame_start=0. After release, first frame_start follows within 2 cycles and an cycles 1110, 1101, 1011, 0111 with 1 dark cycle + 3 lit cycles each.
- digits_in=16'h1234 -> digit0 shows "4" (seg 1001100), digit3 shows "1" (seg 1001111). Frame repeats every 16 cycles.
- digits_in changed 16'h1234 -> 16'h5678 while digit 2 is lit -> digits 2 and 3 still show 2 and 1 in that frame; the next frame shows 8, 7, 6, 5.
- en=0 for one full frame -> an=1111 and seg=1111111 throughout; frame_start still pulses every 16 cycles.
- DISP_LZB_EN, digits_in=16'h0040 -> digits 2 and 3 dark, digit 1 shows "4", digit 0 shows "0". With digits_in=16'h0000, only digit 0 is lit, showing "0".
- rst pulsed while digit 2 is lit -> outputs dark on the next edge; scan resumes at digit 0 with snap reloaded.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display path.
//   seg_t      : segment vector a..g, seg[0] = a, active-low.
//   SEG_BLANK  : all segments dark.
//   GLYPHS     : 16-entry active-low glyph table, 0-9 then A b C d E F.
//   calc_dwell : cycles each digit is held for a given clock/refresh/digit count.
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Literals are written a..g from left to right, matching seg_t's [0:6] order.
    localparam seg_t GLYPHS [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic int calc_dwell(input int clk_hz, input int refresh_hz,
                                      input int n_digits);
        return clk_hz / (refresh_hz * n_digits);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational 4-bit value to active-low 7-segment glyph lookup.
// Shared with the single-digit display path.
//   value : digit value 0..15
//   seg   : glyph, seg[0] = a, active-low
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       seg
);

    assign seg = GLYPHS[value];

endmodule

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed N-digit 7-segment driver. Digit values are snapshotted once
// per refresh frame so a mid-scan counter update never shows a torn display.
//
// Optional build macro:
//   DISP_LZB_EN : leading-zero blanking. A digit above digit 0 is dark when it
//                 and every more significant digit are zero. Its enable still
//                 strobes for its window.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   en          : 1 = display, 0 = all dark (scan keeps running)
//   digits_in   : packed digit values, [3:0] = digit 0
//   seg         : segments a..g, seg[0] = a, active-low, registered
//   an          : digit enables, active-low, an[k] = digit k, registered
//   frame_start : one-cycle pulse while the pins show digit 0, presc 0
// -----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int N_DIGITS   = 4,
    parameter int BLANK_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_in,
    output seg_t                  seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int DWELL = calc_dwell(CLK_HZ, REFRESH_HZ, N_DIGITS);
    localparam int PW    = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam int IW    = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    if (DWELL < 2) begin : g_err_dwell
        $error("seg7_scan_mux: DWELL=%0d, must be at least 2", DWELL);
    end
    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_err_ndig
        $error("seg7_scan_mux: N_DIGITS=%0d, legal range is 2..8", N_DIGITS);
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= DWELL) begin : g_err_blank
        $error("seg7_scan_mux: BLANK_CYC=%0d must be below DWELL=%0d",
               BLANK_CYC, DWELL);
    end

    // ---------------------------------------------------------------------
    // Scan state
    // ---------------------------------------------------------------------
    logic [PW-1:0]              presc;
    logic [IW-1:0]              idx;
    logic [N_DIGITS-1:0][3:0]   snap;
    // Clear only in reset. Forces the snapshot load on the first cycle after
    // release, so the first frame never shows the reset value of snap.
    logic                       loaded;

    logic presc_wrap;
    logic frame_end;
    logic in_blank;

    assign presc_wrap = (presc == PRESC_LAST);
    assign frame_end  = presc_wrap && (idx == IDX_LAST);
    assign in_blank   = (presc < BLANK_END);

    // ---------------------------------------------------------------------
    // Per-digit glyphs from the snapshot
    // ---------------------------------------------------------------------
    seg_t glyph [N_DIGITS];

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
        seg7_decoder u_dec (
            .value (snap[k]),
            .seg   (glyph[k])
        );
    end

    // show[k] = 0 means digit k is blanked by leading-zero suppression.
    logic [N_DIGITS-1:0] show;

`ifdef DISP_LZB_EN
    // Scan from the most significant digit down. A digit is shown once any
    // digit at or above it is non-zero. Digit 0 is always shown, so a value
    // of zero still displays as a single "0".
    always_comb begin
        logic nz;
        show = '0;
        nz   = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            nz      = nz | (snap[k] != 4'd0);
            show[k] = nz | (k == 0);
        end
    end
`else
    assign show = '1;
`endif

    // ---------------------------------------------------------------------
    // Next pin values, computed from the current scan state
    // ---------------------------------------------------------------------
    seg_t                seg_d;
    logic [N_DIGITS-1:0] an_d;
    logic                fs_d;

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        fs_d  = (presc == '0) && (idx == '0);
        if (en && !in_blank) begin
            an_d = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
            if (show[idx]) begin
                seg_d = glyph[idx];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            snap        <= '0;
            loaded      <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            loaded <= 1'b1;

            if (presc_wrap) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // Loaded on the edge that moves idx back to 0, so the whole
            // next frame displays a single consistent value.
            if (frame_end || !loaded) begin
                snap <= digits_in;
            end

            seg         <= seg_d;
            an          <= an_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux. The reference model works in terms of
// frames: it counts cycles since reset release, derives frame number, digit
// and dwell position arithmetically, and keeps one digits_in value per frame.
module tb_seg7_scan_mux;

    localparam int ND = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic [15:0]    din = 16'h0000;
    logic [0:6]     seg;
    logic [ND-1:0]  an;
    logic           frame_start;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .CLK_HZ     (800),
        .REFRESH_HZ (50),
        .N_DIGITS   (ND),
        .BLANK_CYC  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits_in   (din),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    int nchecks = 0;
    int nfail   = 0;

    // Cycles since reset release, and the value each frame should display.
    int          cnt = 0;
    logic [15:0] frames [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Active-high segments a..g with a as the MSB.
    function automatic logic [6:0] lit_segs(input logic [3:0] v);
        case (v)
            4'h0: return 7'h7E;  4'h1: return 7'h30;
            4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;
            4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;
            4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;
            4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // One clock: capture what the DUT sampled at the rising edge, predict the
    // registered pins, then compare on the falling edge.
    task automatic tick();
        logic        s_rst, s_en;
        logic [15:0] s_d, val, sh;
        logic [6:0]  eseg;
        logic [3:0]  ean;
        logic        efs;
        int          c, p, d;
        @(posedge clk);
        s_rst = rst;
        s_en  = en;
        s_d   = din;
        eseg  = 7'h7F;
        ean   = 4'hF;
        efs   = 1'b0;
        c     = -1;
        if (s_rst) begin
            cnt = 0;
            frames.delete();
        end else begin
            c = cnt;
            cnt++;
            p = c % 16;          // position within the 16-cycle frame
            d = p / 4;           // digit being scanned
            if (c == 0 || p == 15) frames.push_back(s_d);
            val = frames[c / 16];
            efs = (p == 0);
            if (s_en && (p % 4) != 0) begin
                sh   = val >> (4 * d);
                ean  = ~(4'b0001 << d);
                eseg = ~lit_segs(sh[3:0]);
`ifdef DISP_LZB_EN
                if (d > 0 && sh == 16'h0000) eseg = 7'h7F;
`endif
            end
        end
        @(negedge clk);
        chk($sformatf("seg c=%0d", c), {25'd0, seg}, {25'd0, eseg});
        chk($sformatf("an c=%0d", c), {28'd0, an}, {28'd0, ean});
        chk($sformatf("frame_start c=%0d", c), {31'd0, frame_start}, {31'd0, efs});
    endtask

    initial begin
        // Reset held 3 cycles: dark pins, no frame_start.
        repeat (3) tick();

        rst = 1'b0;
        en  = 1'b1;
        din = 16'h1234;
        repeat (40) tick();

        // Change the value while digit 2 is in its dwell.
        while (cnt % 16 != 9) tick();
        din = 16'h5678;
        repeat (40) tick();

        // Display disabled for more than one full frame.
        en = 1'b0;
        repeat (20) tick();
        en = 1'b1;
        repeat (8) tick();

        // Values exercising leading zeros.
        din = 16'h0040;
        repeat (36) tick();
        din = 16'h0000;
        repeat (36) tick();
        din = 16'h0A0F;
        repeat (36) tick();

        // Reset pulse in the middle of digit 2's dwell.
        while (cnt % 16 != 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din = 16'($urandom);
        repeat (40) tick();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) din = 16'($urandom);
            if ($urandom_range(0, 15) == 0) din = 16'($urandom_range(0, 255));
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
